// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of mem_port_arbiter, bundled so the arbiter and its
// users connect through a single port. The slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned DATA_BITS = 8
);
    // Fetch requester (read-only)
    logic                 f_req;
    logic [ADDR_BITS-1:0] f_addr;
    logic                 f_gnt;
    logic                 f_rvalid;

    // Data load/store requester
    logic                 d_req;
    logic                 d_we;
    logic [ADDR_BITS-1:0] d_addr;
    logic [DATA_BITS-1:0] d_wdata;
    logic                 d_gnt;
    logic                 d_rvalid;

    // Debug/loader requester
    logic                 g_req;
    logic                 g_we;
    logic                 g_lock;
    logic [ADDR_BITS-1:0] g_addr;
    logic [DATA_BITS-1:0] g_wdata;
    logic                 g_gnt;
    logic                 g_rvalid;

    // Shared read return and memory command
    logic [DATA_BITS-1:0] rdata;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;
    logic                 locked;

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output g_req, g_we, g_lock, g_addr, g_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, d_gnt, d_rvalid, g_gnt, g_rvalid,
        input  rdata, mem_en, mem_we, mem_addr, mem_wdata, locked
    );

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  g_req, g_we, g_lock, g_addr, g_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, d_gnt, d_rvalid, g_gnt, g_rvalid,
        output rdata, mem_en, mem_we, mem_addr, mem_wdata, locked
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter (fetch, data, debug) for a single-port synchronous memory with tagged
// read return and a debug lock. Define MEM_ARB_ROUND_ROBIN_EN for round-robin, else D > F > G.
module mem_port_arbiter #(
    parameter int unsigned ADDR_BITS    = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned READ_LATENCY = 1   // legal 1..4
) (
    input logic              clk,
    input logic              reset_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagF    = 2'd1,
        TagD    = 2'd2,
        TagG    = 2'd3
    } tag_e;

    typedef enum logic {
        StArb,
        StLocked
    } state_e;

    state_e state_q, state_d;

    logic f_gnt, d_gnt, g_gnt, any_gnt;

    logic                 sel_we;
    logic [ADDR_BITS-1:0] sel_addr, addr_q;
    logic [DATA_BITS-1:0] sel_wdata, wdata_q;

    logic [1:0]                    push_tag, out_tag;
    logic [READ_LATENCY-1:0][1:0] tag_q, tag_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last granted requester; the search starts at the one after it.
    logic [1:0] ptr_q, ptr_d;
`endif

    // Grant selection. Grants are suppressed while reset is held.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        g_gnt = 1'b0;
        if (reset_n) begin
            if (state_q == StLocked) begin
                g_gnt = bus.g_req;
            end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                case (ptr_q)
                    TagF: begin
                        if (bus.d_req)      d_gnt = 1'b1;
                        else if (bus.g_req) g_gnt = 1'b1;
                        else if (bus.f_req) f_gnt = 1'b1;
                    end
                    TagD: begin
                        if (bus.g_req)      g_gnt = 1'b1;
                        else if (bus.f_req) f_gnt = 1'b1;
                        else if (bus.d_req) d_gnt = 1'b1;
                    end
                    default: begin
                        if (bus.f_req)      f_gnt = 1'b1;
                        else if (bus.d_req) d_gnt = 1'b1;
                        else if (bus.g_req) g_gnt = 1'b1;
                    end
                endcase
`else
                if (bus.d_req)      d_gnt = 1'b1;
                else if (bus.f_req) f_gnt = 1'b1;
                else if (bus.g_req) g_gnt = 1'b1;
`endif
            end
        end
    end

    assign any_gnt = f_gnt | d_gnt | g_gnt;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StArb: begin
                if (g_gnt && bus.g_lock) state_d = StLocked;
            end
            StLocked: begin
                if (!bus.g_lock) state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Grants made while locked do not move the pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StArb) begin
            if (f_gnt)      ptr_d = TagF;
            else if (d_gnt) ptr_d = TagD;
            else if (g_gnt) ptr_d = TagG;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) ptr_q <= TagG;
        else          ptr_q <= ptr_d;
    end
`endif

    // Command mux; address and write data hold their last value when idle.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        if (f_gnt) begin
            sel_addr = bus.f_addr;
        end else if (d_gnt) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end else if (g_gnt) begin
            sel_we    = bus.g_we;
            sel_addr  = bus.g_addr;
            sel_wdata = bus.g_wdata;
        end
    end

    always_comb begin
        push_tag = TagNone;
        if (f_gnt)                   push_tag = TagF;
        else if (d_gnt && !bus.d_we) push_tag = TagD;
        else if (g_gnt && !bus.g_we) push_tag = TagG;
    end

    // Tag shift register; the last stage lines up with mem_rdata.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = push_tag;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StArb;
            tag_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
        end
    end

    assign out_tag = tag_q[READ_LATENCY-1];

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.g_gnt     = g_gnt;
    assign bus.mem_en    = any_gnt;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    assign bus.f_rvalid = reset_n && (out_tag == TagF);
    assign bus.d_rvalid = reset_n && (out_tag == TagD);
    assign bus.g_rvalid = reset_n && (out_tag == TagG);
    assign bus.rdata    = (reset_n && (out_tag != TagNone)) ? bus.mem_rdata : '0;
    assign bus.locked   = reset_n && (state_q == StLocked);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LATENCY=2, one with 4,
// both fed identical stimulus; memory read data is a fixed function of the address.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        f_req;
    logic [15:0] f_addr;
    logic        d_req, d_we;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        g_req, g_we, g_lock;
    logic [15:0] g_addr;
    logic [7:0]  g_wdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(8)) bus2 ();
    mem_port_arbiter_if #(.ADDR_BITS(16), .DATA_BITS(8)) bus4 ();

    assign bus2.f_req   = f_req;    assign bus4.f_req   = f_req;
    assign bus2.f_addr  = f_addr;   assign bus4.f_addr  = f_addr;
    assign bus2.d_req   = d_req;    assign bus4.d_req   = d_req;
    assign bus2.d_we    = d_we;     assign bus4.d_we    = d_we;
    assign bus2.d_addr  = d_addr;   assign bus4.d_addr  = d_addr;
    assign bus2.d_wdata = d_wdata;  assign bus4.d_wdata = d_wdata;
    assign bus2.g_req   = g_req;    assign bus4.g_req   = g_req;
    assign bus2.g_we    = g_we;     assign bus4.g_we    = g_we;
    assign bus2.g_lock  = g_lock;   assign bus4.g_lock  = g_lock;
    assign bus2.g_addr  = g_addr;   assign bus4.g_addr  = g_addr;
    assign bus2.g_wdata = g_wdata;  assign bus4.g_wdata = g_wdata;

    mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .READ_LATENCY(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    mem_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .READ_LATENCY(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    function automatic logic [7:0] rd(input logic [15:0] a);
        return a[7:0] + 8'h26;
    endfunction

    // Memory models: read data appears READ_LATENCY cycles after the read command.
    logic [7:0] p2 [2];
    logic [7:0] p4 [4];

    always @(posedge clk) begin
        p2[0] <= (bus2.mem_en && !bus2.mem_we) ? rd(bus2.mem_addr) : 8'h00;
        p2[1] <= p2[0];
        p4[0] <= (bus4.mem_en && !bus4.mem_we) ? rd(bus4.mem_addr) : 8'h00;
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end

    assign bus2.mem_rdata = p2[1];
    assign bus4.mem_rdata = p4[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; g_req = 1'b0; g_we = 1'b0; g_lock = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0]  exp_g;
        logic [15:0] exp_a;
        reset_n = 1'b0;
        f_req = 1'b1; d_req = 1'b1; g_req = 1'b1;
        d_we = 1'b0; g_we = 1'b0; g_lock = 1'b0;
        f_addr = 16'h0100; d_addr = 16'h0200; g_addr = 16'h0300;
        d_wdata = 8'h00; g_wdata = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus4.f_gnt, bus4.d_gnt, bus4.g_gnt} !== 6'b0) begin
                errors++;
                $display("FAIL reset_gnt cycle %0d got %b want 000000", i,
                         {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus4.f_gnt, bus4.d_gnt, bus4.g_gnt});
            end
            checks++;
            if ({bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid,
                 bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_rvalid cycle %0d got %b want 000000", i,
                         {bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid,
                          bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid});
            end
            checks++;
            if ({bus2.mem_en, bus2.mem_we, bus2.locked} !== 3'b000) begin
                errors++;
                $display("FAIL reset_en_we_locked cycle %0d got %b want 000", i,
                         {bus2.mem_en, bus2.mem_we, bus2.locked});
            end
            checks++;
            if ({bus2.mem_addr, bus2.mem_wdata, bus2.rdata} !== 32'h0) begin
                errors++;
                $display("FAIL reset_addr_data cycle %0d got %h want 00000000", i,
                         {bus2.mem_addr, bus2.mem_wdata, bus2.rdata});
            end
            tick();
        end
        reset_n = 1'b1;
        @(negedge clk);
        exp_g = RoundRobin ? 3'b100 : 3'b010;
        exp_a = RoundRobin ? 16'h0100 : 16'h0200;
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt} !== exp_g) begin
            errors++;
            $display("FAIL release_first_gnt got %b want %b",
                     {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt}, exp_g);
        end
        checks++;
        if ({bus2.mem_en, bus2.mem_addr} !== {1'b1, exp_a}) begin
            errors++;
            $display("FAIL release_cmd got %h want %h", {bus2.mem_en, bus2.mem_addr}, {1'b1, exp_a});
        end
        tick();
        idle();
        repeat (6) tick();
    endtask

    task automatic test_contention();
        logic [2:0] seq [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
        logic [2:0] exp_g;
        do_reset();
        f_req = 1'b1; d_req = 1'b1; g_req = 1'b1;
        d_we = 1'b0; g_we = 1'b0; g_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_g = RoundRobin ? seq[i] : 3'b010;
            checks++;
            if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt} !== exp_g) begin
                errors++;
                $display("FAIL contention cycle %0d got %b want %b", i,
                         {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt}, exp_g);
            end
            tick();
        end
        idle();
        repeat (6) tick();
    endtask

    task automatic test_single_read();
        logic [2:0] exp_rv;
        logic [7:0] exp_rd;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1234;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt} !== 3'b010) begin
            errors++;
            $display("FAIL single_read_gnt got %b want 010", {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt});
        end
        checks++;
        if ({bus2.mem_en, bus2.mem_we, bus2.mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
            errors++;
            $display("FAIL single_read_cmd got %h want %h",
                     {bus2.mem_en, bus2.mem_we, bus2.mem_addr}, {1'b1, 1'b0, 16'h1234});
        end
        tick();
        idle();
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            exp_rv = (i == 2) ? 3'b010 : 3'b000;
            exp_rd = (i == 2) ? 8'h5A : 8'h00;
            checks++;
            if ({bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid, bus2.rdata} !== {exp_rv, exp_rd}) begin
                errors++;
                $display("FAIL single_read_return N+%0d got %h want %h", i,
                         {bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid, bus2.rdata}, {exp_rv, exp_rd});
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_lock_burst();
        logic [15:0] a;
        logic [7:0]  w;
        f_addr = 16'h0400;
        for (int k = 0; k < 4; k++) begin
            a = 16'hFF00 + k[15:0];
            w = 8'hA0 + k[7:0];
            g_req = 1'b1; g_we = 1'b1; g_addr = a; g_wdata = w; g_lock = (k < 3);
            f_req = (k > 0);
            @(negedge clk);
            checks++;
            if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked} !== {3'b001, (k > 0)}) begin
                errors++;
                $display("FAIL lock_burst_gnt_locked write %0d got %b want %b", k,
                         {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked}, {3'b001, (k > 0)});
            end
            checks++;
            if ({bus2.mem_we, bus2.mem_addr, bus2.mem_wdata} !== {1'b1, a, w}) begin
                errors++;
                $display("FAIL lock_burst_cmd write %0d got %h want %h", k,
                         {bus2.mem_we, bus2.mem_addr, bus2.mem_wdata}, {1'b1, a, w});
            end
            tick();
        end
        g_req = 1'b0; g_we = 1'b0; g_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked} !== 4'b1000) begin
            errors++;
            $display("FAIL lock_burst_after got %b want 1000",
                     {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked});
        end
        tick();
        idle();
        repeat (6) tick();
    endtask

    task automatic test_lock_idle();
        g_req = 1'b1; g_we = 1'b1; g_addr = 16'h0500; g_wdata = 8'h11; g_lock = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt} !== 3'b001) begin
            errors++;
            $display("FAIL lock_idle_enter got %b want 001", {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt});
        end
        tick();
        g_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0600; d_wdata = 8'h22;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.mem_en, bus2.locked} !== 5'b00001) begin
            errors++;
            $display("FAIL lock_idle_hold got %b want 00001",
                     {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.mem_en, bus2.locked});
        end
        checks++;
        if ({bus2.mem_addr, bus2.mem_wdata} !== {16'h0500, 8'h11}) begin
            errors++;
            $display("FAIL lock_idle_held_cmd got %h want 050011", {bus2.mem_addr, bus2.mem_wdata});
        end
        tick();
        g_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked} !== 4'b0001) begin
            errors++;
            $display("FAIL lock_idle_exit_cycle got %b want 0001",
                     {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked} !== 4'b0100) begin
            errors++;
            $display("FAIL lock_idle_unlocked got %b want 0100",
                     {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt, bus2.locked});
        end
        tick();
        idle();
        repeat (6) tick();
    endtask

    task automatic test_in_flight();
        logic [2:0] exp_rv;
        logic [7:0] exp_rd;
        f_req = 1'b1; f_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if ({bus4.f_gnt, bus4.d_gnt, bus4.g_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL in_flight_f_gnt got %b want 100", {bus4.f_gnt, bus4.d_gnt, bus4.g_gnt});
        end
        tick();
        f_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 8'h33;
        @(negedge clk);
        checks++;
        if ({bus4.f_gnt, bus4.d_gnt, bus4.g_gnt, bus4.mem_we} !== 4'b0101) begin
            errors++;
            $display("FAIL in_flight_d_gnt got %b want 0101",
                     {bus4.f_gnt, bus4.d_gnt, bus4.g_gnt, bus4.mem_we});
        end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0030; g_lock = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus4.f_gnt, bus4.d_gnt, bus4.g_gnt} !== 3'b001) begin
            errors++;
            $display("FAIL in_flight_g_gnt got %b want 001", {bus4.f_gnt, bus4.d_gnt, bus4.g_gnt});
        end
        tick();
        idle();
        for (int i = 3; i < 9; i++) begin
            @(negedge clk);
            exp_rv = (i == 4) ? 3'b100 : ((i == 6) ? 3'b001 : 3'b000);
            exp_rd = (i == 4) ? 8'h36 : ((i == 6) ? 8'h56 : 8'h00);
            checks++;
            if ({bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid, bus4.rdata} !== {exp_rv, exp_rd}) begin
                errors++;
                $display("FAIL in_flight_return N+%0d got %h want %h", i,
                         {bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid, bus4.rdata}, {exp_rv, exp_rd});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(negedge clk);
        checks++;
        if ({bus2.f_gnt, bus2.d_gnt, bus2.g_gnt} !== 3'b010) begin
            errors++;
            $display("FAIL reset_mid_gnt got %b want 010", {bus2.f_gnt, bus2.d_gnt, bus2.g_gnt});
        end
        tick();
        idle();
        reset_n = 1'b0;
        for (int i = 1; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if ({bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid,
                 bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid_rvalid N+%0d got %b want 000000", i,
                         {bus2.f_rvalid, bus2.d_rvalid, bus2.g_rvalid,
                          bus4.f_rvalid, bus4.d_rvalid, bus4.g_rvalid});
            end
            tick();
            reset_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_read();
        test_lock_burst();
        test_lock_idle();
        test_in_flight();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
